// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round-constant tables, round count per word width,
// and the sequencer state encoding.
package sha2_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic int ROUNDS_OF(input int word_w);
    return (word_w == 64) ? 80 : 64;
  endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// Combinational K lookup: LANES consecutive round constants starting at base,
// lane 0 in the LSBs.
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LANES  = 1
) (
  input  logic [6:0]              base,
  output logic [LANES*WORD_W-1:0] k
);

  localparam int ROUNDS = ROUNDS_OF(WORD_W);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [6:0] idx;

    // The counter parks at ROUNDS after the last beat; fold it back into the table.
    always_comb begin
      idx = base + 7'(j);
      if (idx >= 7'(ROUNDS)) idx = idx - 7'(ROUNDS);
    end

    if (WORD_W == 64) begin : g_k512
      assign k[j*WORD_W +: WORD_W] = K512[idx];
    end else begin : g_k256
      logic unused_hi;
      assign unused_hi = idx[6];
      assign k[j*WORD_W +: WORD_W] = K256[idx[5:0]];
    end
  end

endmodule

// File: rtl/sha2_k_sequencer.sv
// SHA-2 round-constant sequencer streaming LANES K (or K+W) words per beat.
// Macro SHA2_KW_ADD_EN: when defined, W beats are consumed and pre-added to K.
module sha2_k_sequencer
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    w_valid_i,
  input  logic [LANES*WORD_W-1:0] w_i,
  output logic                    w_ready_o,
  output logic                    kw_valid_o,
  input  logic                    kw_ready_i,
  output logic [LANES*WORD_W-1:0] kw_o,
  output logic [6:0]              t_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int ROUNDS = ROUNDS_OF(WORD_W);
  localparam int BUS_W  = LANES*WORD_W;

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha2_k_sequencer: WORD_W must be 32 or 64");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("sha2_k_sequencer: LANES must be 1, 2 or 4");
  end

  state_t           state;
  logic [6:0]       t;
  logic [BUS_W-1:0] k;
  logic [BUS_W-1:0] kw_next;
  logic             out_free;
  logic             load;
  logic             is_last;

  sha2_k_rom #(.WORD_W(WORD_W), .LANES(LANES)) u_rom (
    .base (t),
    .k    (k)
  );

  assign out_free = !kw_valid_o || kw_ready_i;
  assign is_last  = (t + 7'(LANES)) == 7'(ROUNDS);
  assign busy_o   = (state != ST_IDLE);

`ifdef SHA2_KW_ADD_EN
  function automatic logic [WORD_W-1:0] add_wrap(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
    return a + b;
  endfunction

  assign w_ready_o = (state == ST_RUN) && out_free;
  assign load      = w_valid_i && w_ready_o;

  for (genvar j = 0; j < LANES; j++) begin : g_add
    assign kw_next[j*WORD_W +: WORD_W] = add_wrap(k[j*WORD_W +: WORD_W], w_i[j*WORD_W +: WORD_W]);
  end
`else
  logic unused_w;
  assign unused_w  = ^{w_valid_i, w_i};
  assign w_ready_o = 1'b0;
  assign load      = (state == ST_RUN) && out_free;
  assign kw_next   = k;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      t          <= '0;
      kw_valid_o <= 1'b0;
      kw_o       <= '0;
      t_o        <= '0;
      last_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state      <= ST_IDLE;
        t          <= '0;
        kw_valid_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              state <= ST_RUN;
              t     <= '0;
            end
          end
          ST_RUN: begin
            if (load) begin
              kw_o       <= kw_next;
              t_o        <= t;
              last_o     <= is_last;
              kw_valid_o <= 1'b1;
              t          <= t + 7'(LANES);
              if (is_last) state <= ST_DRAIN;
            end else if (kw_valid_o && kw_ready_i) begin
              kw_valid_o <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (kw_valid_o && kw_ready_i) begin
              kw_valid_o <= 1'b0;
              done_o     <= 1'b1;
              state      <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Scoreboard bench for sha2_k_sequencer: three instances (32x1, 64x4, 32x2),
// exercised one at a time; add-mode checks follow SHA2_KW_ADD_EN.
module tb_sha2_k_sequencer;
  import sha2_pkg::*;

`ifdef SHA2_KW_ADD_EN
  localparam bit ADD = 1'b1;
`else
  localparam bit ADD = 1'b0;
`endif
  localparam int WW [3] = '{32, 64, 32};
  localparam int LN [3] = '{1, 4, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   start = '0, abort = '0, w_valid = '0, kw_ready = '0;
  logic [31:0]  w_a = '0;
  logic [255:0] w_b = '0;
  logic [63:0]  w_c = '0;
  logic [31:0]  kw_a;
  logic [255:0] kw_b;
  logic [63:0]  kw_c;
  logic [6:0]   t_a, t_b, t_c;
  wire  [2:0]   kv, lst, bsy, dn, wr;

  sha2_k_sequencer #(.WORD_W(32), .LANES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .abort_i(abort[0]),
    .w_valid_i(w_valid[0]), .w_i(w_a), .w_ready_o(wr[0]), .kw_valid_o(kv[0]),
    .kw_ready_i(kw_ready[0]), .kw_o(kw_a), .t_o(t_a), .last_o(lst[0]),
    .busy_o(bsy[0]), .done_o(dn[0]));

  sha2_k_sequencer #(.WORD_W(64), .LANES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .abort_i(abort[1]),
    .w_valid_i(w_valid[1]), .w_i(w_b), .w_ready_o(wr[1]), .kw_valid_o(kv[1]),
    .kw_ready_i(kw_ready[1]), .kw_o(kw_b), .t_o(t_b), .last_o(lst[1]),
    .busy_o(bsy[1]), .done_o(dn[1]));

  sha2_k_sequencer #(.WORD_W(32), .LANES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .abort_i(abort[2]),
    .w_valid_i(w_valid[2]), .w_i(w_c), .w_ready_o(wr[2]), .kw_valid_o(kv[2]),
    .kw_ready_i(kw_ready[2]), .kw_o(kw_c), .t_o(t_c), .last_o(lst[2]),
    .busy_o(bsy[2]), .done_o(dn[2]));

  typedef struct {
    logic [255:0] kw;
    int           t;
    bit           last;
  } beat_t;

  beat_t        sb[$];
  int           nvec = 0, nmis = 0;
  int           sel = 0, wmode = 0, rmode = 0, wt = 0, cyc = 0, exp_done = -1;
  int           blk_beats = 0;
  bit           saw_done = 0, held_v = 0;
  logic [255:0] held_kw, blk_first, blk_last_kw;
  logic [7:0]   held_tl;
  logic [6:0]   blk_first_t, blk_last_t;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] cur_kw();
    case (sel)
      0:       return 256'(kw_a);
      1:       return kw_b;
      default: return 256'(kw_c);
    endcase
  endfunction

  function automatic logic [6:0] cur_t();
    case (sel)
      0:       return t_a;
      1:       return t_b;
      default: return t_c;
    endcase
  endfunction

  function automatic logic [63:0] wmask();
    return (WW[sel] == 64) ? 64'hffffffff_ffffffff : 64'h00000000_ffffffff;
  endfunction

  function automatic logic [63:0] wpat(input int r);
    logic [31:0] ru;
    ru = 32'(r);
    case (wmode)
      0:       return 64'h0;
      1:       return 64'hffffffff_ffffffff;
      default: return {ru * 32'h9e3779b9, (ru + 32'd5) * 32'h7f4a7c15};
    endcase
  endfunction

  // Reference K+W (or K) for the beat whose lane 0 is round t.
  function automatic logic [255:0] exp_kw(input int t);
    logic [255:0] r;
    logic [63:0]  kj;
    r = '0;
    for (int j = 0; j < LN[sel]; j++) begin
      if (WW[sel] == 64) kj = K512[7'(t + j)];
      else               kj = {32'h0, K256[6'(t + j)]};
      if (ADD) kj = kj + wpat(t + j);
      kj = kj & wmask();
      r = r | (256'(kj) << (j * WW[sel]));
    end
    return r;
  endfunction

  task automatic drive_w();
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < LN[sel]; j++)
      v = v | (256'(wpat(wt + j) & wmask()) << (j * WW[sel]));
    case (sel)
      0:       w_a = v[31:0];
      1:       w_b = v;
      default: w_c = v[63:0];
    endcase
  endtask

  task automatic tick();
    bit    acc;
    beat_t e;
    @(negedge clk);
    check("done", 256'(dn[sel]), 256'(cyc == exp_done));
    if (dn[sel]) saw_done = 1'b1;
    if (!ADD) check("w_ready_low", 256'(wr[sel]), 256'(0));
    if (held_v && kv[sel]) begin
      check("hold_kw", cur_kw(), held_kw);
      check("hold_t_last", 256'({cur_t(), lst[sel]}), 256'(held_tl));
    end
    held_v = kv[sel] && !kw_ready[sel];
    held_kw = cur_kw();
    held_tl = {cur_t(), lst[sel]};
    if (kv[sel] && kw_ready[sel]) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 256'(cur_t()), 256'hdead);
      end else begin
        e = sb.pop_front();
        check("kw", cur_kw(), e.kw);
        check("t", 256'(cur_t()), 256'(e.t));
        check("last", 256'(lst[sel]), 256'(e.last));
        if (blk_beats == 0) begin
          blk_first = cur_kw();
          blk_first_t = cur_t();
        end
        blk_beats++;
        if (lst[sel]) begin
          blk_last_kw = cur_kw();
          blk_last_t = cur_t();
          exp_done = cyc + 1;
        end
      end
    end
    acc = w_valid[sel] && wr[sel];
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      wt += LN[sel];
      drive_w();
    end
    kw_ready[sel] = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'b0;
  endtask

  task automatic begin_block();
    int r;
    r = ROUNDS_OF(WW[sel]);
    sb.delete();
    blk_beats = 0;
    exp_done = -1;
    saw_done = 1'b0;
    held_v = 1'b0;
    wt = 0;
    drive_w();
    for (int t = 0; t < r; t += LN[sel]) sb.push_back('{exp_kw(t), t, (t + LN[sel] == r)});
    kw_ready[sel] = (rmode != 2);
    w_valid[sel] = ADD;
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
  endtask

  task automatic run_block();
    begin_block();
    for (int n = 0; n < 1000 && !saw_done; n++) tick();
    check("block_done", 256'(saw_done), 256'(1));
    check("sb_left", 256'(sb.size()), 256'(0));
    tick();
    check("idle_after", 256'(bsy[sel]), 256'(0));
    w_valid[sel] = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 256'({kv, lst, bsy, dn, wr}), 256'(0));
    check("rst_kw_a", 256'(kw_a), 256'(0));
    check("rst_kw_b", kw_b, 256'(0));
    check("rst_kw_c", 256'(kw_c), 256'(0));
    check("rst_t", 256'({t_a, t_b, t_c}), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit, one lane, W=0, free-running output
    sel = 0; wmode = 0; rmode = 0;
    run_block();
    check("a_beat0", blk_first, 256'h428a2f98);
    check("a_beat63", blk_last_kw, 256'hc67178f2);
    check("a_last_t", 256'(blk_last_t), 256'(63));
    check("a_beats", 256'(blk_beats), 256'(64));

    if (ADD) begin
      wmode = 1;
      run_block();
      check("a_wrap", blk_first, 256'h428a2f97);
    end

    // Backpressure with ready toggling every cycle
    wmode = 2; rmode = 1;
    run_block();
    check("bp_beats", 256'(blk_beats), 256'(64));

    // Abort together with start at t=30
    wmode = 0; rmode = 0;
    begin_block();
    for (int n = 0; n < 200 && !(kv[sel] && cur_t() == 7'd30); n++) tick();
    check("abort_reach", 256'(kv[sel] && cur_t() == 7'd30), 256'(1));
    abort[sel] = 1'b1;
    start[sel] = 1'b1;
    rmode = 2;
    kw_ready[sel] = 1'b0;
    tick();
    abort[sel] = 1'b0;
    start[sel] = 1'b0;
    w_valid[sel] = 1'b0;
    check("abort_busy", 256'(bsy[sel]), 256'(0));
    check("abort_kv", 256'(kv[sel]), 256'(0));
    sb.delete();
    repeat (4) tick();
    check("abort_no_done", 256'(saw_done), 256'(0));
    rmode = 0;
    run_block();
    check("restart_t0", 256'(blk_first_t), 256'(0));
    check("restart_beats", 256'(blk_beats), 256'(64));

    // 64-bit, four lanes
    sel = 1; wmode = 0; rmode = 0;
    run_block();
    check("b_beat0", blk_first, {64'he9b5dba58189dbbc, 64'hb5c0fbcfec4d3b2f,
                                 64'h7137449123ef65cd, 64'h428a2f98d728ae22});
    check("b_beats", 256'(blk_beats), 256'(20));
    check("b_last_t", 256'(blk_last_t), 256'(76));

    // 32-bit, two lanes
    sel = 2; wmode = 0; rmode = 0;
    run_block();
    check("c_beat0", blk_first, 256'h71374491_428a2f98);
    check("c_beats", 256'(blk_beats), 256'(32));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
